servo_adc_sampler: RTL and testbench
====================================

Name: servo_adc_sampler

Overview:
- Upstream stage of the servo PWM controller's current-protection path.
- On each measurement_trigger pulse from the PWM generator, runs one burst of four single-ended conversions on the board's LTC2308 SPI ADC, channels 0..3.
- Drives the four phase-current words i0..i3 that the overcurrent protect block compares against its limits.
- Updates all four words atomically and flags the update with a one-cycle sample_valid.

Parameters:
- ADC_WIDTH, 12, result width; must equal the controller's ADC_WIDTH.
- SCK_HALF, 2, clk cycles per SCK half-period (25 MHz SCK at 100 MHz clk); legal range 2..15.
- CONVST_CYCLES, 4, CONVST high time in clk cycles.
- CONV_CYCLES, 170, CONVST-low wait for conversion before shifting (at least 1.6 us).
- GAP_CYCLES, 8, idle clk cycles between frames (ADC acquisition time).

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  accept new triggers when high
- measurement_trigger  in  1  one-cycle start pulse from the PWM generator
- adc_convst  out  1  LTC2308 CONVST
- adc_sck  out  1  SPI clock, idle low
- adc_sdi  out  1  6-bit config word, MSB first
- adc_sdo  in  1  conversion result, MSB first
- i0, i1, i2, i3  out  ADC_WIDTH each  latched results for channels 0..3
- sample_valid  out  1  one-cycle pulse when i0..i3 update
- busy  out  1  high from trigger acceptance until sample_valid
- trig_overrun  out  1  one-cycle pulse when a trigger arrives while busy

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. On reset, all outputs are 0 (adc_convst, adc_sck, adc_sdi, i0..i3, sample_valid, busy, trig_overrun); the FSM returns to IDLE and the frame counter is cleared. Reset asserted mid-burst aborts immediately; no partial results are published.
- Config words (S/D O/S S1 S0 UNI SLP): CH0=6'b100010, CH1=6'b110010, CH2=6'b100110, CH3=6'b110110.
- Pipelining: each frame sends the config word for the next conversion while reading back the previous one. A burst is therefore 5 frames, f=0..4:
  - Frame f sends the config for channel f; frame 4 re-sends CH0 as a dummy.
  - Frame 0 readback is discarded; frame f (1..4) readback is channel f-1.
- FSM states: IDLE -> CONVST -> CONV_WAIT -> SHIFT -> GAP -> CONVST ... -> DONE -> IDLE.
  - IDLE: if measurement_trigger && enable, set busy and go to CONVST with f=0. Otherwise the trigger is ignored with no flag.
  - CONVST: adc_convst=1 for CONVST_CYCLES cycles.
  - CONV_WAIT: adc_convst=0 for CONV_CYCLES cycles.
  - SHIFT: 12 SCK periods, each SCK_HALF cycles low then SCK_HALF cycles high.
    - adc_sdi changes only while SCK is low: bit 5-k during period k (k=0..5), then 0.
    - adc_sdo is sampled in the clk cycle where SCK goes high (no synchroniser) and shifted into a 12-bit register, MSB first.
    - SCK returns low at the end of period 11.
  - GAP: after SHIFT of frames 0..3, wait GAP_CYCLES cycles, then f++ and go to CONVST.
  - After SHIFT of frame 4, go to DONE.
- Result capture: frames 1..3 store into shadow registers. DONE copies the shadows plus the frame-4 result to i0..i3 in one cycle, asserts sample_valid for that cycle, clears busy, and returns to IDLE.
- Latency: from the trigger cycle in IDLE to sample_valid = 5*(CONVST_CYCLES+CONV_CYCLES+24*SCK_HALF) + 4*GAP_CYCLES + 1 = 1143 cycles with defaults.
- Next trigger: accepted in the cycle after sample_valid.
- Trigger while busy (any state other than IDLE): ignored, and trig_overrun pulses for 1 cycle. A trigger in the same cycle as DONE counts as an overrun.
- Deasserting enable mid-burst does not abort; the burst completes and publishes. New triggers are ignored while enable=0.
- Between bursts, i0..i3 hold their last values.

Decomposition:
- Package servo_adc_pkg holds:
  - the four LTC2308 config-word constants;
  - the FSM state encoding;
  - the frame count constant (5) and the SHIFT bit count (12).
- One sub-module, servo_adc_spi_frame, performs a single SHIFT phase:
  - inputs start and cfg[5:0]; outputs sck, sdi, result[11:0], done;
  - SCK_HALF is its parameter.
- The top level owns the CONVST/CONV_WAIT/GAP timing, frame sequencing, and output registers.

Test Plan:
- Basic burst:
  - Stimulus: ADC model returns 0x123, 0x456, 0x789, 0xABC for ch0..3; one trigger.
  - Required: exactly one sample_valid 1143 cycles later; i0..i3 equal those values; 60 SCK rising edges total; 5 CONVST pulses of 4 cycles each.
- SDI protocol check:
  - Stimulus: capture adc_sdi at each SCK rise in frames 0..4.
  - Required: 100010, 110010, 100110, 110110, 100010 in order, each followed by six zeros; adc_sdi is stable while SCK is high.
- Overrun:
  - Stimulus: second trigger at cycle 500 of a burst, and another in the DONE cycle.
  - Required: two trig_overrun pulses; only one sample_valid; no second burst starts.
- Enable gating:
  - Stimulus: enable=0 with a trigger; then enable=1 with a trigger and enable dropped at cycle 200.
  - Required: first trigger gives no activity; second burst completes and publishes.
- Reset mid-burst:
  - Stimulus: reset_n low for 1 cycle at cycle 700, then a new trigger.
  - Required: all outputs 0 the cycle after reset; no sample_valid from the aborted burst; the new burst publishes correct values.
- Extremes:
  - Stimulus: ADC returns 0x000 and 0xFFF alternately; SCK_HALF=3.
  - Required: exact values captured; latency = 5*(4+170+72)+32+1 = 1263 cycles.

Source files
------------

// File: rtl/servo_adc_sampler_pkg.sv
// Shared constants and types for the servo current sampler: LTC2308 config words,
// FSM state encoding and burst geometry.
package servo_adc_pkg;

  // S/D O/S S1 S0 UNI SLP: single-ended, unipolar, no sleep
  localparam logic [5:0] CFG_CH0 = 6'b100010;
  localparam logic [5:0] CFG_CH1 = 6'b110010;
  localparam logic [5:0] CFG_CH2 = 6'b100110;
  localparam logic [5:0] CFG_CH3 = 6'b110110;

  localparam int unsigned FRAMES     = 5;
  localparam int unsigned SHIFT_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVST,
    ST_CONV_WAIT,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  // Frame f programs channel f; the last frame re-sends CH0 as a dummy.
  function automatic logic [5:0] frame_cfg(input logic [2:0] frame);
    case (frame)
      3'd1:    return CFG_CH1;
      3'd2:    return CFG_CH2;
      3'd3:    return CFG_CH3;
      default: return CFG_CH0;
    endcase
  endfunction

endpackage

// File: rtl/servo_adc_sampler_if.sv
// LTC2308 SPI/CONVST bus between the sampler (master) and the ADC (slave).
interface servo_adc_sampler_if;
  logic adc_convst;
  logic adc_sck;
  logic adc_sdi;
  logic adc_sdo;

  modport master (output adc_convst, adc_sck, adc_sdi, input adc_sdo);
  modport slave  (input adc_convst, adc_sck, adc_sdi, output adc_sdo);
endinterface

// File: rtl/servo_adc_sampler_spi_frame.sv
// One LTC2308 SHIFT phase: 12 SCK periods sending a 6-bit config word while
// shifting the previous conversion result in, MSB first.
module servo_adc_spi_frame
  import servo_adc_pkg::*;
#(
  parameter int unsigned SCK_HALF = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [5:0]            cfg,
  input  logic                  sdo,
  output logic                  sck,
  output logic                  sdi,
  output logic [SHIFT_BITS-1:0] result,
  output logic                  done
);

  localparam logic [3:0] HALF_LAST   = 4'(SCK_HALF - 1);
  localparam logic [3:0] PERIOD_LAST = 4'(SHIFT_BITS - 1);

  logic       active;
  logic [3:0] half_cnt;
  logic [3:0] period;
  logic [5:0] cfg_sr;
  logic       half_end;

  assign half_end = active && (half_cnt == HALF_LAST);
  // sck doubles as the low/high phase flag of the current period
  assign done     = half_end && sck && (period == PERIOD_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active   <= 1'b0;
      half_cnt <= '0;
      period   <= '0;
      cfg_sr   <= '0;
      sck      <= 1'b0;
      sdi      <= 1'b0;
      result   <= '0;
    end else if (start) begin
      active   <= 1'b1;
      half_cnt <= '0;
      period   <= '0;
      sck      <= 1'b0;
      sdi      <= cfg[5];
      cfg_sr   <= {cfg[4:0], 1'b0};
    end else if (active) begin
      half_cnt <= half_end ? '0 : half_cnt + 4'd1;
      if (half_end) begin
        if (!sck) begin
          sck    <= 1'b1;
          result <= {result[SHIFT_BITS-2:0], sdo};
        end else begin
          sck <= 1'b0;
          if (period == PERIOD_LAST) begin
            active <= 1'b0;
            sdi    <= 1'b0;
          end else begin
            period <= period + 4'd1;
            sdi    <= cfg_sr[5];
            cfg_sr <= {cfg_sr[4:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/servo_adc_sampler.sv
// Servo phase-current sampler: per trigger, a pipelined 5-frame LTC2308 burst over
// channels 0..3, published atomically with a one-cycle sample_valid.
module servo_adc_sampler
  import servo_adc_pkg::*;
#(
  parameter int unsigned ADC_WIDTH     = 12,
  parameter int unsigned SCK_HALF      = 2,
  parameter int unsigned CONVST_CYCLES = 4,
  parameter int unsigned CONV_CYCLES   = 170,
  parameter int unsigned GAP_CYCLES    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   measurement_trigger,
  servo_adc_sampler_if.master    adc,
  output logic [ADC_WIDTH-1:0]   i0,
  output logic [ADC_WIDTH-1:0]   i1,
  output logic [ADC_WIDTH-1:0]   i2,
  output logic [ADC_WIDTH-1:0]   i3,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   trig_overrun
);

  localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [2:0]  FRAME_LAST  = 3'(FRAMES - 1);

  state_t                 state, state_next;
  logic [15:0]            cnt, cnt_next;
  logic [2:0]             frame, frame_next;
  logic                   spi_start;
  logic                   spi_done;
  logic [SHIFT_BITS-1:0]  spi_result;
  logic [5:0]             cfg;
  logic                   convst;
  logic                   sck;
  logic                   sdi;
  logic [ADC_WIDTH-1:0]   sh0, sh1, sh2;

  assign cfg            = frame_cfg(frame);
  assign adc.adc_convst = convst;
  assign adc.adc_sck    = sck;
  assign adc.adc_sdi    = sdi;

  servo_adc_spi_frame #(.SCK_HALF(SCK_HALF)) u_spi (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (spi_start),
    .cfg    (cfg),
    .sdo    (adc.adc_sdo),
    .sck    (sck),
    .sdi    (sdi),
    .result (spi_result),
    .done   (spi_done)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 16'd1;
    frame_next = frame;
    spi_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (measurement_trigger && enable) begin
          state_next = ST_CONVST;
          frame_next = '0;
        end
      end
      ST_CONVST: if (cnt == CONVST_LAST) begin
        state_next = ST_CONV_WAIT;
        cnt_next   = '0;
      end
      ST_CONV_WAIT: if (cnt == CONV_LAST) begin
        state_next = ST_SHIFT;
        cnt_next   = '0;
        spi_start  = 1'b1;
      end
      ST_SHIFT: begin
        cnt_next = '0;
        if (spi_done) state_next = (frame == FRAME_LAST) ? ST_DONE : ST_GAP;
      end
      ST_GAP: if (cnt == GAP_LAST) begin
        state_next = ST_CONVST;
        cnt_next   = '0;
        frame_next = frame + 3'd1;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      frame        <= '0;
      convst       <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      trig_overrun <= 1'b0;
      sh0          <= '0;
      sh1          <= '0;
      sh2          <= '0;
      i0           <= '0;
      i1           <= '0;
      i2           <= '0;
      i3           <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      frame        <= frame_next;
      convst       <= (state_next == ST_CONVST);
      busy         <= (state_next != ST_IDLE);
      sample_valid <= (state_next == ST_DONE);
      trig_overrun <= measurement_trigger && (state != ST_IDLE);
      if (state == ST_SHIFT && spi_done) begin
        case (frame)
          3'd1: sh0 <= spi_result[ADC_WIDTH-1:0];
          3'd2: sh1 <= spi_result[ADC_WIDTH-1:0];
          3'd3: sh2 <= spi_result[ADC_WIDTH-1:0];
          3'd4: begin
            i0 <= sh0;
            i1 <= sh1;
            i2 <= sh2;
            i3 <= spi_result[ADC_WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_adc_sampler.sv
// Bench for servo_adc_sampler: two instances (SCK_HALF=2 and 3) against an LTC2308
// behavioural model and a burst-timeline model of the expected outputs.
module tb_servo_adc_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        en    [2];
  logic        trig  [2];
  logic        sdo   [2];
  logic [11:0] i0_w [2], i1_w [2], i2_w [2], i3_w [2];
  logic        sv_w [2], busy_w [2], ovr_w [2];
  logic        cv_w [2], sck_w [2], sdi_w [2];

  servo_adc_sampler_if bus_a ();
  servo_adc_sampler_if bus_b ();

  assign bus_a.adc_sdo = sdo[0];
  assign bus_b.adc_sdo = sdo[1];
  assign cv_w[0]  = bus_a.adc_convst;
  assign sck_w[0] = bus_a.adc_sck;
  assign sdi_w[0] = bus_a.adc_sdi;
  assign cv_w[1]  = bus_b.adc_convst;
  assign sck_w[1] = bus_b.adc_sck;
  assign sdi_w[1] = bus_b.adc_sdi;

  servo_adc_sampler #(.ADC_WIDTH(12), .SCK_HALF(2), .CONVST_CYCLES(4),
                      .CONV_CYCLES(170), .GAP_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .enable(en[0]), .measurement_trigger(trig[0]),
    .adc(bus_a), .i0(i0_w[0]), .i1(i1_w[0]), .i2(i2_w[0]), .i3(i3_w[0]),
    .sample_valid(sv_w[0]), .busy(busy_w[0]), .trig_overrun(ovr_w[0])
  );

  servo_adc_sampler #(.ADC_WIDTH(12), .SCK_HALF(3), .CONVST_CYCLES(4),
                      .CONV_CYCLES(170), .GAP_CYCLES(8)) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .enable(en[1]), .measurement_trigger(trig[1]),
    .adc(bus_b), .i0(i0_w[1]), .i1(i1_w[1]), .i2(i2_w[1]), .i3(i3_w[1]),
    .sample_valid(sv_w[1]), .busy(busy_w[1]), .trig_overrun(ovr_w[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", name, g, act, exp, $time);
    end
  endtask

  // ---------------- expected-behaviour model ----------------
  logic [11:0] val   [2][4];
  logic [11:0] exp_i [2][4];
  logic        exp_ovr [2];
  int          m [2];

  function automatic int half_of(input int g);
    return (g == 0) ? 2 : 3;
  endfunction

  function automatic int lat_of(input int g);
    return 5 * (4 + 170 + 24 * half_of(g)) + 4 * 8 + 1;
  endfunction

  function automatic logic [5:0] cfg_of(input int f);
    case (f)
      1:       return 6'b110010;
      2:       return 6'b100110;
      3:       return 6'b110110;
      default: return 6'b100010;
    endcase
  endfunction

  // Expected CONVST/SCK/SDI at cycle mm of a burst (cycle 1 = first cycle after the trigger)
  task automatic exp_sig(input int g, input int mm, output logic cv, output logic sck, output logic sdi);
    int hh, p, off, f, s, k;
    logic [5:0] c;
    cv = 1'b0; sck = 1'b0; sdi = 1'b0;
    hh = half_of(g);
    p  = 4 + 170 + 24 * hh + 8;
    if (mm >= 1 && mm < lat_of(g)) begin
      off = (mm - 1) % p;
      f   = (mm - 1) / p;
      cv  = (off < 4);
      s   = off - 174;
      if (s >= 0 && s < 24 * hh) begin
        k   = s / (2 * hh);
        sck = ((s % (2 * hh)) >= hh);
        c   = cfg_of(f);
        if (k < 6) sdi = c[5 - k];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      bit nonidle;
      nonidle = (m[g] >= 1) && (m[g] <= lat_of(g));
      if (!rst_n[g]) begin
        m[g] = -1;
        exp_ovr[g] = 1'b0;
        for (int c = 0; c < 4; c++) exp_i[g][c] = '0;
      end else begin
        exp_ovr[g] = trig[g] && nonidle;
        if (trig[g] && en[g] && !nonidle) m[g] = 1;
        else if (nonidle && m[g] < lat_of(g)) m[g] = m[g] + 1;
        else m[g] = -1;
        if (m[g] == lat_of(g))
          for (int c = 0; c < 4; c++) exp_i[g][c] = val[g][c];
      end
    end
  end

  // ---------------- LTC2308 model, event counters and per-cycle compare ----------------
  logic        prev_cv [2], prev_sck [2];
  logic [11:0] word [2];
  logic [5:0]  cfg_sh [2], cfg_pend [2];
  int          cfg_bits [2];
  int          sv_cnt [2], ovr_cnt [2], sck_rise [2], cv_rise [2], cv_hi [2];
  logic [59:0] sdi_log;

  function automatic logic [11:0] adc_lookup(input int g, input logic [5:0] c);
    case (c)
      6'b100010: return val[g][0];
      6'b110010: return val[g][1];
      6'b100110: return val[g][2];
      6'b110110: return val[g][3];
      default:   return 12'hBAD;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic e_cv, e_sck, e_sdi;
      if (cv_w[g] === 1'b1 && prev_cv[g] !== 1'b1) begin
        word[g]     = adc_lookup(g, cfg_pend[g]);
        sdo[g]      = word[g][11];
        cfg_bits[g] = 0;
        cv_rise[g]++;
      end
      if (cv_w[g] === 1'b1) cv_hi[g]++;
      if (sck_w[g] === 1'b1 && prev_sck[g] !== 1'b1) begin
        sck_rise[g]++;
        if (cfg_bits[g] < 6) begin
          cfg_sh[g] = {cfg_sh[g][4:0], sdi_w[g]};
          cfg_bits[g]++;
          if (cfg_bits[g] == 6) cfg_pend[g] = cfg_sh[g];
        end
        if (g == 0) sdi_log = {sdi_log[58:0], sdi_w[0]};
      end
      if (sck_w[g] === 1'b0 && prev_sck[g] === 1'b1) begin
        word[g] = {word[g][10:0], 1'b0};
        sdo[g]  = word[g][11];
      end
      if (sv_w[g] === 1'b1)  sv_cnt[g]++;
      if (ovr_w[g] === 1'b1) ovr_cnt[g]++;
      prev_cv[g]  = cv_w[g];
      prev_sck[g] = sck_w[g];

      if (chk_on) begin
        exp_sig(g, m[g], e_cv, e_sck, e_sdi);
        chk("busy",         g, busy_w[g], (m[g] >= 1));
        chk("sample_valid", g, sv_w[g],   (m[g] == lat_of(g)));
        chk("trig_overrun", g, ovr_w[g],  exp_ovr[g]);
        chk("adc_convst",   g, cv_w[g],   e_cv);
        chk("adc_sck",      g, sck_w[g],  e_sck);
        chk("adc_sdi",      g, sdi_w[g],  e_sdi);
        chk("i0",           g, i0_w[g],   exp_i[g][0]);
        chk("i1",           g, i1_w[g],   exp_i[g][1]);
        chk("i2",           g, i2_w[g],   exp_i[g][2]);
        chk("i3",           g, i3_w[g],   exp_i[g][3]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Call just after a negedge; the trigger is sampled at the following posedge (cycle 0).
  task automatic burst(input int g, input int ovr_at, input bit trig_done,
                       input int drop_at, input int rst_at, output int lat);
    lat = -1;
    trig[g] = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      trig[g]  = 1'b0;
      rst_n[g] = 1'b1;
      if (rst_at > 0 && n == rst_at + 1) break;
      if (n == ovr_at)  trig[g]  = 1'b1;
      if (n == drop_at) en[g]    = 1'b0;
      if (n == rst_at)  rst_n[g] = 1'b0;
      if (sv_w[g] === 1'b1) begin
        lat = n;
        trig[g] = trig_done;
        break;
      end
    end
    @(negedge clk);
    trig[g] = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, s_sv, s_ovr, s_sck, s_cv, s_cvh;
    logic [59:0] sdi_exp;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; en[g] = 1'b0; trig[g] = 1'b0; sdo[g] = 1'b0;
      m[g] = -1; exp_ovr[g] = 1'b0;
      prev_cv[g] = 1'b0; prev_sck[g] = 1'b0; word[g] = '0;
      cfg_sh[g] = '0; cfg_pend[g] = '0; cfg_bits[g] = 6;
      sv_cnt[g] = 0; ovr_cnt[g] = 0; sck_rise[g] = 0; cv_rise[g] = 0; cv_hi[g] = 0;
      for (int c = 0; c < 4; c++) begin val[g][c] = '0; exp_i[g][c] = '0; end
    end
    sdi_log = '0;

    @(negedge clk);
    chk_on = 1'b1;
    wait_cyc(2);
    chk("reset_busy", 0, busy_w[0], 1'b0);
    chk("reset_i3",   1, i3_w[1],   12'h000);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    wait_cyc(3);

    // Basic burst
    val[0][0] = 12'h123; val[0][1] = 12'h456; val[0][2] = 12'h789; val[0][3] = 12'hABC;
    en[0] = 1'b1;
    s_sck = sck_rise[0]; s_cv = cv_rise[0]; s_cvh = cv_hi[0]; s_sv = sv_cnt[0];
    sdi_log = '0;
    burst(0, 0, 1'b0, 0, 0, lat);
    chk("basic_latency", 0, lat, 1143);
    chk("basic_i0", 0, i0_w[0], 12'h123);
    chk("basic_i1", 0, i1_w[0], 12'h456);
    chk("basic_i2", 0, i2_w[0], 12'h789);
    chk("basic_i3", 0, i3_w[0], 12'hABC);
    chk("basic_sck_rises", 0, sck_rise[0] - s_sck, 60);
    chk("basic_convst_pulses", 0, cv_rise[0] - s_cv, 5);
    chk("basic_convst_cycles", 0, cv_hi[0] - s_cvh, 20);
    chk("basic_sv_count", 0, sv_cnt[0] - s_sv, 1);
    sdi_exp = 60'b100010000000_110010000000_100110000000_110110000000_100010000000;
    chk("sdi_sequence", 0, sdi_log, sdi_exp);
    wait_cyc(5);

    // Overrun: mid-burst trigger and a trigger in the DONE cycle
    val[0][0] = 12'h0F1; val[0][1] = 12'h2E3; val[0][2] = 12'h4D5; val[0][3] = 12'h6C7;
    s_ovr = ovr_cnt[0]; s_sv = sv_cnt[0]; s_cv = cv_rise[0];
    burst(0, 500, 1'b1, 0, 0, lat);
    wait_cyc(50);
    chk("overrun_latency", 0, lat, 1143);
    chk("overrun_pulses", 0, ovr_cnt[0] - s_ovr, 2);
    chk("overrun_sv_count", 0, sv_cnt[0] - s_sv, 1);
    chk("overrun_no_second_burst", 0, cv_rise[0] - s_cv, 5);
    chk("overrun_i2", 0, i2_w[0], 12'h4D5);

    // Enable gating
    en[0] = 1'b0;
    s_cv = cv_rise[0];
    trig[0] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    wait_cyc(50);
    chk("disabled_no_convst", 0, cv_rise[0] - s_cv, 0);
    chk("disabled_busy", 0, busy_w[0], 1'b0);
    val[0][0] = 12'h5A5; val[0][1] = 12'hA5A; val[0][2] = 12'h3C3; val[0][3] = 12'hC3C;
    en[0] = 1'b1;
    burst(0, 0, 1'b0, 200, 0, lat);
    chk("enable_drop_latency", 0, lat, 1143);
    chk("enable_drop_i1", 0, i1_w[0], 12'hA5A);
    chk("enable_drop_i3", 0, i3_w[0], 12'hC3C);
    en[0] = 1'b1;
    wait_cyc(5);

    // Reset mid-burst
    val[0][0] = 12'h111; val[0][1] = 12'h222; val[0][2] = 12'h333; val[0][3] = 12'h444;
    s_sv = sv_cnt[0];
    burst(0, 0, 1'b0, 0, 700, lat);
    chk("reset_abort_i0", 0, i0_w[0], 12'h000);
    chk("reset_abort_busy", 0, busy_w[0], 1'b0);
    wait_cyc(1300);
    chk("reset_abort_no_sv", 0, sv_cnt[0] - s_sv, 0);
    val[0][0] = 12'h8E1; val[0][1] = 12'h7D2; val[0][2] = 12'h6C3; val[0][3] = 12'h5B4;
    burst(0, 0, 1'b0, 0, 0, lat);
    chk("after_reset_latency", 0, lat, 1143);
    chk("after_reset_i0", 0, i0_w[0], 12'h8E1);
    chk("after_reset_i3", 0, i3_w[0], 12'h5B4);

    // Extremes on the SCK_HALF=3 instance
    en[1] = 1'b1;
    val[1][0] = 12'h000; val[1][1] = 12'hFFF; val[1][2] = 12'h000; val[1][3] = 12'hFFF;
    burst(1, 0, 1'b0, 0, 0, lat);
    chk("extreme_latency", 1, lat, 1263);
    chk("extreme_i0", 1, i0_w[1], 12'h000);
    chk("extreme_i1", 1, i1_w[1], 12'hFFF);
    chk("extreme_i3", 1, i3_w[1], 12'hFFF);
    wait_cyc(3);
    val[1][0] = 12'hFFF; val[1][1] = 12'h000; val[1][2] = 12'hFFF; val[1][3] = 12'h000;
    burst(1, 0, 1'b0, 0, 0, lat);
    chk("extreme2_latency", 1, lat, 1263);
    chk("extreme2_i0", 1, i0_w[1], 12'hFFF);
    chk("extreme2_i2", 1, i2_w[1], 12'hFFF);
    chk("extreme2_i3", 1, i3_w[1], 12'h000);
    wait_cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
